// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: wraps a payload stream with SOF, MAC/type header, optional pad, EOF.
// Optional minimum-length padding is enabled by defining ETH_TX_FRAMER_PAD_EN.
module eth_tx_framer #(
  parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_00_00_01,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic [47:0] dst_mac_in,
  input  logic [15:0] ethertype_in,
  input  logic [7:0]  pl_d_in,
  input  logic        pl_valid_in,
  input  logic        pl_last_in,
  output logic        pl_rd_out,
  output logic        wr_en_out,
  output logic [8:0]  wr_d_out,
  input  logic        wr_full_in,
  output logic        busy_out,
  output logic        err_out
);

`ifdef ETH_TX_FRAMER_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  localparam logic [10:0] MaxCnt   = 11'(MAX_PAYLOAD);
  // Payload count at which the last pad byte is written (46 bytes after the 14-byte header).
  localparam logic [10:0] PadLast  = 11'd45;
  localparam logic [8:0]  WordSof  = 9'h100;
  localparam logic [8:0]  WordEof  = 9'h101;
  localparam logic [8:0]  WordErr  = 9'h103;

  typedef enum logic [2:0] {
    StIdle, StSof, StHdr, StPayload, StPad, StEof, StErr, StDrain
  } state_e;

  state_e      state_q;
  logic [47:0] dst_q;
  logic [15:0] type_q;
  logic [3:0]  hdr_cnt_q;
  logic [10:0] pl_cnt_q;

  logic [7:0]  hdr_byte;
  logic        at_max;
  logic        wr_en;

  assign at_max = (pl_cnt_q == MaxCnt);

  always_comb begin
    hdr_byte = 8'h00;
    unique case (hdr_cnt_q)
      4'd0:    hdr_byte = dst_q[47:40];
      4'd1:    hdr_byte = dst_q[39:32];
      4'd2:    hdr_byte = dst_q[31:24];
      4'd3:    hdr_byte = dst_q[23:16];
      4'd4:    hdr_byte = dst_q[15:8];
      4'd5:    hdr_byte = dst_q[7:0];
      4'd6:    hdr_byte = SRC_MAC[47:40];
      4'd7:    hdr_byte = SRC_MAC[39:32];
      4'd8:    hdr_byte = SRC_MAC[31:24];
      4'd9:    hdr_byte = SRC_MAC[23:16];
      4'd10:   hdr_byte = SRC_MAC[15:8];
      4'd11:   hdr_byte = SRC_MAC[7:0];
      4'd12:   hdr_byte = type_q[15:8];
      4'd13:   hdr_byte = type_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Outputs are decoded straight from state so a stalled word stays on wr_d_out.
  always_comb begin
    wr_en     = 1'b0;
    wr_d_out  = 9'h000;
    pl_rd_out = 1'b0;
    err_out   = 1'b0;
    unique case (state_q)
      StSof: begin
        wr_en    = !wr_full_in;
        wr_d_out = WordSof;
      end
      StHdr: begin
        wr_en    = !wr_full_in;
        wr_d_out = {1'b0, hdr_byte};
      end
      StPayload: begin
        wr_d_out = {1'b0, pl_d_in};
        if (pl_valid_in && !at_max) begin
          wr_en     = !wr_full_in;
          pl_rd_out = !wr_full_in;
        end
      end
      StPad: begin
        wr_en    = !wr_full_in;
        wr_d_out = 9'h000;
      end
      StEof: begin
        wr_en    = !wr_full_in;
        wr_d_out = WordEof;
      end
      StErr: begin
        wr_en     = !wr_full_in;
        wr_d_out  = WordErr;
        err_out   = !wr_full_in;
        // A final offending byte is swallowed together with the error word.
        pl_rd_out = !wr_full_in && pl_valid_in && pl_last_in;
      end
      StDrain: begin
        pl_rd_out = pl_valid_in;
      end
      default: ;
    endcase
  end

  assign wr_en_out = wr_en;
  assign busy_out  = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dst_q     <= 48'h0;
      type_q    <= 16'h0;
      hdr_cnt_q <= 4'd0;
      pl_cnt_q  <= 11'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            dst_q     <= dst_mac_in;
            type_q    <= ethertype_in;
            hdr_cnt_q <= 4'd0;
            pl_cnt_q  <= 11'd0;
            state_q   <= StSof;
          end
        end
        StSof: begin
          if (wr_en) state_q <= StHdr;
        end
        StHdr: begin
          if (wr_en) begin
            if (hdr_cnt_q == 4'd13) begin
              state_q <= StPayload;
            end else begin
              hdr_cnt_q <= hdr_cnt_q + 4'd1;
            end
          end
        end
        StPayload: begin
          if (pl_valid_in && !wr_full_in) begin
            if (at_max) begin
              state_q <= StErr;
            end else begin
              pl_cnt_q <= pl_cnt_q + 11'd1;
              if (pl_last_in) begin
                if (PadEn && (pl_cnt_q < PadLast)) state_q <= StPad;
                else                               state_q <= StEof;
              end
            end
          end
        end
        StPad: begin
          if (wr_en) begin
            pl_cnt_q <= pl_cnt_q + 11'd1;
            if (pl_cnt_q >= PadLast) state_q <= StEof;
          end
        end
        StEof: begin
          if (wr_en) state_q <= StIdle;
        end
        StErr: begin
          if (wr_en) begin
            if (pl_valid_in && pl_last_in) state_q <= StIdle;
            else                           state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pl_valid_in && pl_last_in) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: driver pushes expected FIFO words, monitor pops and compares.
module tb_eth_tx_framer;

  localparam logic [47:0] SrcMac = 48'h00_0A_35_00_00_01;
  localparam int MaxPl = 1500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic [47:0] dst_mac_in = '0;
  logic [15:0] ethertype_in = '0;
  logic [7:0]  pl_d_in = '0;
  logic        pl_valid_in = 1'b0;
  logic        pl_last_in = 1'b0;
  logic        pl_rd_out;
  logic        wr_en_out;
  logic [8:0]  wr_d_out;
  logic        wr_full_in = 1'b0;
  logic        busy_out;
  logic        err_out;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int rd_viol = 0;
  logic [8:0] exp_q[$];

  eth_tx_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_in     (start_in),
    .dst_mac_in   (dst_mac_in),
    .ethertype_in (ethertype_in),
    .pl_d_in      (pl_d_in),
    .pl_valid_in  (pl_valid_in),
    .pl_last_in   (pl_last_in),
    .pl_rd_out    (pl_rd_out),
    .wr_en_out    (wr_en_out),
    .wr_d_out     (wr_d_out),
    .wr_full_in   (wr_full_in),
    .busy_out     (busy_out),
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pl_byte(input int i);
    return 8'((i * 7) + 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor samples just before the rising edge, after the driver has settled inputs.
  always @(negedge clk) begin
    #4;
    if (wr_en_out) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL word: got %03h, expected no write", wr_d_out);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (wr_d_out !== e) begin
          fails++;
          $display("FAIL word: got %03h, expected %03h", wr_d_out, e);
        end
      end
    end
    if (err_out) err_cnt++;
    if (pl_rd_out && wr_full_in) rd_viol++;
  end

  task automatic push_frame(input logic [47:0] dst, input logic [15:0] et, input int len);
    int n;
    exp_q.push_back(9'h100);
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, dst[47 - 8*i -: 8]});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, SrcMac[47 - 8*i -: 8]});
    exp_q.push_back({1'b0, et[15:8]});
    exp_q.push_back({1'b0, et[7:0]});
    n = (len > MaxPl) ? MaxPl : len;
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pl_byte(i)});
    if (len > MaxPl) begin
      exp_q.push_back(9'h103);
    end else begin
`ifdef ETH_TX_FRAMER_PAD_EN
      for (int i = len; i < 46; i++) exp_q.push_back(9'h000);
`endif
      exp_q.push_back(9'h101);
    end
  endtask

  task automatic run_frame(input string name, input logic [47:0] dst, input logic [15:0] et,
                           input int len, input bit toggle);
    int  idx;
    bit  done;
    push_frame(dst, et, len);
    @(negedge clk);
    dst_mac_in   = dst;
    ethertype_in = et;
    start_in     = 1'b1;
    pl_valid_in  = 1'b0;
    @(negedge clk);
    start_in = 1'b0;
    idx  = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      wr_full_in  = toggle ? cyc[0] : 1'b0;
      pl_valid_in = (idx < len);
      pl_d_in     = pl_byte(idx);
      pl_last_in  = (idx == len - 1);
      #3;
      if (pl_rd_out) idx++;
      if (!busy_out) begin
        done = 1'b1;
        break;
      end
    end
    wr_full_in  = 1'b0;
    pl_valid_in = 1'b0;
    pl_last_in  = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: busy still high after 5000 cycles", name);
    end
    check({name, " bytes consumed"}, idx, len);
    check({name, " queue drained"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " wr_en"}, wr_en_out, 0);
    check({name, " wr_d"}, wr_d_out, 0);
    check({name, " pl_rd"}, pl_rd_out, 0);
    check({name, " busy"}, busy_out, 0);
    check({name, " err"}, err_out, 0);
  endtask

  initial begin
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("arp28", 48'hFFFF_FFFF_FFFF, 16'h0806, 28, 1'b0);
    run_frame("stall100", 48'h0123_4567_89AB, 16'h0800, 100, 1'b1);
    run_frame("oversize", 48'h1122_3344_5566, 16'h86DD, 1510, 1'b0);
    check("err pulses", err_cnt, 1);

    // Abort mid-header: SOF plus three destination bytes precede the reset.
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h0DE);
    exp_q.push_back(9'h0AD);
    exp_q.push_back(9'h0BE);
    @(negedge clk);
    dst_mac_in   = 48'hDEAD_BEEF_CAFE;
    ethertype_in = 16'h0800;
    start_in     = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero("midhdr reset");
    check("midhdr words seen", exp_q.size(), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    run_frame("fresh50", 48'hA0B1_C2D3_E4F5, 16'h0800, 50, 1'b0);
    repeat (3) @(negedge clk);
    check("final err pulses", err_cnt, 1);
    check("pl_rd while full", rd_viol, 0);
    check("final queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter SRC_MAC, default 48'h00_0A_35_00_00_01, source MAC inserted in every frame.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 1500, maximum payload bytes accepted per frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_in  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-006 SHALL have port dst_mac_in  input  48  destination MAC, latched at accepted start_in.
REQ-007 SHALL have port ethertype_in  input  16  type field, latched at accepted start_in.
REQ-008 SHALL have port pl_d_in  input  8  payload byte.
REQ-009 SHALL have port pl_valid_in  input  1  pl_d_in valid.
REQ-010 SHALL have port pl_last_in  input  1  marks final payload byte.
REQ-011 SHALL have port pl_rd_out  output  1  payload byte consumed this cycle.
REQ-012 SHALL have port wr_en_out  output  1  write strobe to the transmit FIFO.
REQ-013 SHALL have port wr_d_out  output  9  FIFO word: bit 8 control flag, bits 7:0 data or control code.
REQ-014 SHALL have port wr_full_in  input  1  transmit FIFO full.
REQ-015 SHALL have port busy_out  output  1  high in every state except IDLE.
REQ-016 SHALL have port err_out  output  1  one-cycle pulse when an error word is written.

Function
REQ-017 SHALL implement states IDLE, SOF, HDR, PAYLOAD, PAD, EOF, ERR, DRAIN.
REQ-018 SHALL, in IDLE with start_in high, latch dst_mac_in/ethertype_in, clear counters, enter SOF next cycle.
REQ-019 SHALL drive wr_en_out combinationally as (state in SOF/HDR/PAYLOAD-with-pl_valid_in/PAD/EOF/ERR) AND NOT wr_full_in; state advances only on cycles where wr_en_out is high.
REQ-020 SHALL write in SOF word 9'h100, then enter HDR.
REQ-021 SHALL write in HDR 14 data words (bit 8 = 0): dst MAC MSB byte first, SRC_MAC MSB byte first, ethertype high then low byte; 4-bit counter 0..13, then PAYLOAD.
REQ-022 SHALL assert pl_rd_out in PAYLOAD exactly when pl_valid_in high and wr_full_in low, writing {1'b0, pl_d_in} in the same cycle; zero latency.
REQ-023 SHALL count payload bytes in an 11-bit counter incremented per consumed byte.
REQ-024 SHALL on consuming a byte with pl_last_in high go to PAD if padding is required (REQ-034), else EOF.
REQ-025 SHALL write in PAD data words 9'h000 until header+payload+pad totals 60 bytes, then EOF.
REQ-026 SHALL write in EOF word 9'h101, then return to IDLE.
REQ-027 SHALL, when a valid payload byte arrives with counter already equal to MAX_PAYLOAD, not consume it, enter ERR.
REQ-028 SHALL write in ERR word 9'h103, pulse err_out in that cycle, then enter DRAIN (or IDLE if the offending byte carried pl_last_in, consuming it with the error write).
REQ-029 SHALL in DRAIN assert pl_rd_out = pl_valid_in, write nothing, return to IDLE after consuming a byte with pl_last_in.
REQ-030 SHALL hold pl_rd_out low in all states other than PAYLOAD, ERR (REQ-028 case) and DRAIN.
REQ-031 SHALL ignore start_in while busy_out is high; no queuing.
REQ-032 SHALL hold wr_d_out at its state-defined word whenever stalled by wr_full_in.

Reset
REQ-033 SHALL on rst_n low immediately force state IDLE, counters 0, latched header 0, wr_en_out 0, wr_d_out 0, pl_rd_out 0, busy_out 0, err_out 0; a partially written frame is abandoned without EOF.

Configuration
REQ-034 SHALL, with macro ETH_TX_FRAMER_PAD_EN defined, pad frames whose payload is under 46 bytes per REQ-025; without it, PAD state is never entered and short frames go directly to EOF.

Verification
REQ-035 SHALL cover: start_in, dst 48'hFFFFFFFFFFFF, type 16'h0806, 28-byte payload, PAD_EN on -> 100, FF x6, SRC_MAC x6, 08, 06, 28 bytes, 18 x 000, 101 (62 words).
REQ-036 SHALL cover: same 28-byte frame, PAD_EN off -> 44 words ending 101, no zero pad.
REQ-037 SHALL cover: 100-byte payload, wr_full_in toggling every other cycle -> identical word sequence (116 words), no duplicates or drops, pl_rd_out only when wr_full_in low.
REQ-038 SHALL cover: 1510-byte payload, MAX_PAYLOAD 1500 -> 1500 data words then 103, err_out one pulse, remaining 10 bytes drained, no 101, IDLE after last.
REQ-039 SHALL cover: rst_n low mid-HDR -> all outputs 0 same cycle, next start_in produces fresh frame beginning 100.
